pit_event_sched: RTL and testbench

PIT_EVENT_SCHED -- requirements
Module: pit_event_sched

---
 rtl/pit_sched_pkg.sv | 17 +
 rtl/pit_event_sched_if.sv | 27 ++
 rtl/pit_rr_arbiter.sv | 30 +++
 rtl/pit_event_sched.sv | 141 ++++++++++++++
 tb/tb_pit_event_sched.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pit_sched_pkg.sv
// rtl/pit_sched_pkg.sv - shared defaults, FSM state type and index wrap helper for the PIT event scheduler
package pit_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } sched_state_e;

  // Operands never exceed 2*n-1, so a single subtract is a full modulo.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/pit_event_sched_if.sv
// rtl/pit_event_sched_if.sv - channel configuration and event handshake bundle of the PIT event scheduler
interface pit_event_sched_if
  import pit_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int CH_W = $clog2(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             evt_valid;
  logic [CH_W-1:0]  evt_ch;
  logic             evt_ready;

  modport master (
    output cfg_we, cfg_ch, cfg_period, evt_ready,
    input  evt_valid, evt_ch
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, evt_ready,
    output evt_valid, evt_ch
  );

endinterface

// File: rtl/pit_rr_arbiter.sv
// rtl/pit_rr_arbiter.sv - stateless round-robin pick of the first pending channel at or after the pointer
module pit_rr_arbiter
  import pit_sched_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_pending_o
);

  logic [CH_W-1:0] idx;

  // Walk from farthest to nearest so the channel closest to the pointer wins.
  always_comb begin
    grant_o       = '0;
    any_pending_o = 1'b0;
    idx           = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'(rr_wrap(int'(ptr_i) + k, NUM_CH));
      if (pending_i[idx]) begin
        grant_o       = idx;
        any_pending_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pit_event_sched.sv
// rtl/pit_event_sched.sv - multiplexes one PIT tick into NUM_CH periodic virtual timers with a round-robin event port
// Optional sticky overrun tracking is built when PIT_EVENT_SCHED_OVERRUN_EN is defined.
module pit_event_sched
  import pit_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                tick_in,
  pit_event_sched_if.slave    bus,
  output logic [NUM_CH-1:0]   overrun,
  input  logic [NUM_CH-1:0]   overrun_clr
);

  localparam int CH_W = $clog2(NUM_CH);

  logic                tick_q;
  logic [CNT_W-1:0]    period_q [NUM_CH];
  logic [CNT_W-1:0]    period_d [NUM_CH];
  logic [CNT_W-1:0]    cnt_q    [NUM_CH];
  logic [CNT_W-1:0]    cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   ovr_set;
  sched_state_e        state_q, state_d;
  logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     grant;
  logic                any_pending;
  logic                tick, hs;
  logic                cfg_hit, hs_hit, active, expire;

  assign tick          = tick_in & ~tick_q;
  assign hs            = (state_q == PRESENT) & bus.evt_ready;
  assign bus.evt_valid = (state_q == PRESENT);
  assign bus.evt_ch    = evt_ch_q;

  pit_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pending_i     (pending_q),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .any_pending_o (any_pending)
  );

  // Configuration writes take priority over expiry and handshake on the same channel.
  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovr_set   = '0;
    cfg_hit   = 1'b0;
    hs_hit    = 1'b0;
    active    = 1'b0;
    expire    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
      hs_hit  = hs && (evt_ch_q == CH_W'(i));
      active  = tick && (period_q[i] != '0);
      expire  = active && (cnt_q[i] <= CNT_W'(1));
      if (cfg_hit) begin
        period_d[i]  = bus.cfg_period;
        cnt_d[i]     = bus.cfg_period;
        pending_d[i] = 1'b0;
      end else begin
        if (active) begin
          cnt_d[i] = expire ? period_q[i] : cnt_q[i] - 1'b1;
        end
        if (expire) begin
          pending_d[i] = 1'b1;
          ovr_set[i]   = pending_q[i] & ~hs_hit;
        end else if (hs_hit) begin
          pending_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          state_d  = PRESENT;
          evt_ch_d = grant;
        end
      end
      PRESENT: begin
        if (hs) begin
          state_d = IDLE;
          ptr_d   = CH_W'(rr_wrap(int'(evt_ch_q) + 1, NUM_CH));
        end else if ((bus.cfg_we && (bus.cfg_ch == evt_ch_q)) || !pending_q[evt_ch_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      tick_q    <= 1'b0;
      period_q  <= '{default: '0};
      cnt_q     <= '{default: '0};
      pending_q <= '0;
      state_q   <= IDLE;
      evt_ch_q  <= '0;
      ptr_q     <= '0;
    end else begin
      tick_q    <= tick_in;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      evt_ch_q  <= evt_ch_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef PIT_EVENT_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_q;

  // A new overrun in the same cycle as its clear keeps the flag set.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= (overrun_q & ~overrun_clr) | ovr_set;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_ovr;
  assign unused_ovr = ^{overrun_clr, ovr_set};
  assign overrun    = '0;
`endif

endmodule

// File: tb/tb_pit_event_sched.sv
// tb/tb_pit_event_sched.sv - directed self-checking bench for pit_event_sched
module tb_pit_event_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic [3:0] overrun;
  logic [3:0] overrun_clr = 4'b0;
  int         total = 0;
  int         bad = 0;
  int         hs_cnt = 0;
  logic [1:0] last_ch = 2'd0;

  pit_event_sched_if #(.NUM_CH(4), .CNT_W(16)) bus ();

  pit_event_sched #(.NUM_CH(4), .CNT_W(16)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .tick_in      (tick_in),
    .bus          (bus),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      hs_cnt  = hs_cnt + 1;
      last_ch = bus.evt_ch;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick;
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int per);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = 2'(ch);
    bus.cfg_period = 16'(per);
    @(negedge clk);
    bus.cfg_we     = 1'b0;
  endtask

  task automatic test_reset;
    int base;
    idle(3);
    rst = 1'b0;
    total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.evt_valid); end
    total++; if (bus.evt_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", bus.evt_ch); end
    total++; if (overrun !== 4'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0000", overrun); end
    base = hs_cnt;
    bus.evt_ready = 1'b1;
    do_tick;
    idle(3);
    total++; if (hs_cnt - base !== 0) begin bad++; $display("FAIL reset_no_periods got=%0d exp=0", hs_cnt - base); end
  endtask

  task automatic test_period;
    int base;
    int exp_cnt [7] = '{0, 0, 1, 1, 1, 2, 2};
    do_reset;
    bus.evt_ready = 1'b1;
    cfg_write(0, 3);
    base = hs_cnt;
    for (int t = 1; t <= 7; t++) begin
      do_tick;
      if (t == 3) begin
        total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL period_latency_early got=%0b exp=0", bus.evt_valid); end
        idle(1);
        total++; if ({bus.evt_valid, bus.evt_ch} !== 3'b100) begin bad++; $display("FAIL period_latency got=%b exp=100", {bus.evt_valid, bus.evt_ch}); end
      end
      idle(4);
      total++; if (hs_cnt - base !== exp_cnt[t-1]) begin bad++; $display("FAIL period_count tick=%0d got=%0d exp=%0d", t, hs_cnt - base, exp_cnt[t-1]); end
    end
    total++; if (last_ch !== 2'd0) begin bad++; $display("FAIL period_ch got=%0d exp=0", last_ch); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_ch;
    do_reset;
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) cfg_write(c, 1);
    do_tick;
    for (int j = 0; j < 9; j++) begin
      idle(1);
      exp_ch = 2'(j / 2);
      if (j % 2 == 0 && j < 8) begin
        total++; if ({bus.evt_valid, bus.evt_ch} !== {1'b1, exp_ch}) begin bad++; $display("FAIL rr_grant slot=%0d got=%b exp=%b", j, {bus.evt_valid, bus.evt_ch}, {1'b1, exp_ch}); end
      end else begin
        total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL rr_gap slot=%0d got=%0b exp=0", j, bus.evt_valid); end
      end
    end
  endtask

  task automatic test_overrun;
    int base;
    logic [3:0] exp_ovr;
`ifdef PIT_EVENT_SCHED_OVERRUN_EN
    exp_ovr = 4'b0010;
`else
    exp_ovr = 4'b0000;
`endif
    do_reset;
    bus.evt_ready = 1'b0;
    cfg_write(1, 2);
    base = hs_cnt;
    for (int t = 1; t <= 5; t++) begin
      do_tick;
      idle(1);
      if (t >= 2) begin
        total++; if ({bus.evt_valid, bus.evt_ch} !== 3'b101) begin bad++; $display("FAIL ovr_hold tick=%0d got=%b exp=101", t, {bus.evt_valid, bus.evt_ch}); end
      end
    end
    total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL ovr_flag got=%b exp=%b", overrun, exp_ovr); end
    @(negedge clk) overrun_clr = 4'b0010;
    @(negedge clk) overrun_clr = 4'b0000;
    total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL ovr_clear got=%b exp=0000", overrun); end
    @(negedge clk);
    tick_in = 1'b1;
    overrun_clr = 4'b0010;
    @(negedge clk);
    tick_in = 1'b0;
    overrun_clr = 4'b0000;
    idle(1);
    total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL ovr_set_wins got=%b exp=%b", overrun, exp_ovr); end
    bus.evt_ready = 1'b1;
    idle(3);
    total++; if (hs_cnt - base !== 1 || last_ch !== 2'd1) begin bad++; $display("FAIL ovr_drain got=%0d/%0d exp=1/1", hs_cnt - base, last_ch); end
  endtask

  task automatic test_cfg_tick;
    int base;
    do_reset;
    bus.evt_ready = 1'b1;
    cfg_write(2, 1);
    base = hs_cnt;
    @(negedge clk);
    tick_in = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 2'd2;
    bus.cfg_period = 16'd5;
    @(negedge clk);
    tick_in = 1'b0;
    bus.cfg_we = 1'b0;
    idle(3);
    total++; if (hs_cnt - base !== 0 || bus.evt_valid !== 1'b0) begin bad++; $display("FAIL cfg_override got=%0d/%0b exp=0/0", hs_cnt - base, bus.evt_valid); end
    for (int t = 1; t <= 5; t++) begin
      do_tick;
      idle(3);
      total++; if (hs_cnt - base !== ((t == 5) ? 1 : 0)) begin bad++; $display("FAIL cfg_reload tick=%0d got=%0d exp=%0d", t, hs_cnt - base, (t == 5) ? 1 : 0); end
    end
    total++; if (last_ch !== 2'd2) begin bad++; $display("FAIL cfg_reload_ch got=%0d exp=2", last_ch); end
  endtask

  task automatic test_hold_high;
    int base;
    do_reset;
    bus.evt_ready = 1'b1;
    cfg_write(0, 1);
    base = hs_cnt;
    @(negedge clk) tick_in = 1'b1;
    idle(10);
    tick_in = 1'b0;
    idle(5);
    total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL hold_high got=%0d exp=1", hs_cnt - base); end
  endtask

  task automatic test_cfg_cancel;
    int base;
    do_reset;
    bus.evt_ready = 1'b0;
    cfg_write(0, 1);
    do_tick;
    idle(1);
    total++; if ({bus.evt_valid, bus.evt_ch} !== 3'b100) begin bad++; $display("FAIL cancel_pre got=%b exp=100", {bus.evt_valid, bus.evt_ch}); end
    base = hs_cnt;
    cfg_write(0, 0);
    total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL cancel_drop got=%0b exp=0", bus.evt_valid); end
    cfg_write(1, 1);
    cfg_write(0, 1);
    do_tick;
    idle(1);
    total++; if ({bus.evt_valid, bus.evt_ch} !== 3'b100 || hs_cnt !== base) begin bad++; $display("FAIL cancel_ptr got=%b hs=%0d exp=100 hs=%0d", {bus.evt_valid, bus.evt_ch}, hs_cnt, base); end
  endtask

  task automatic test_reset_present;
    int base;
    logic [3:0] exp_ovr;
`ifdef PIT_EVENT_SCHED_OVERRUN_EN
    exp_ovr = 4'b0101;
`else
    exp_ovr = 4'b0000;
`endif
    do_reset;
    bus.evt_ready = 1'b0;
    cfg_write(0, 1);
    cfg_write(2, 1);
    do_tick;
    do_tick;
    idle(1);
    total++; if ({bus.evt_valid, overrun} !== {1'b1, exp_ovr}) begin bad++; $display("FAIL rstp_pre got=%b exp=%b", {bus.evt_valid, overrun}, {1'b1, exp_ovr}); end
    do_reset;
    total++; if ({bus.evt_valid, bus.evt_ch, overrun} !== 7'b0) begin bad++; $display("FAIL rstp_clear got=%b exp=0000000", {bus.evt_valid, bus.evt_ch, overrun}); end
    base = hs_cnt;
    bus.evt_ready = 1'b1;
    do_tick;
    do_tick;
    idle(3);
    total++; if (hs_cnt - base !== 0 || bus.evt_valid !== 1'b0) begin bad++; $display("FAIL rstp_periods got=%0d/%0b exp=0/0", hs_cnt - base, bus.evt_valid); end
  endtask

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_ch = 2'd0;
    bus.cfg_period = 16'd0;
    bus.evt_ready = 1'b0;
    test_reset;
    test_period;
    test_back_to_back;
    test_overrun;
    test_cfg_tick;
    test_hold_high;
    test_cfg_cancel;
    test_reset_present;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
